// File: rtl/ca_sweep_scheduler.sv
// Move sequencer for the 8x8 automaton: request capture, 64-cell sweep, atomic commit.
// Define CA_REQ_QUEUE_EN to queue requests that arrive while a move is running.
module ca_sweep_scheduler #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int QDEPTH        = 4,
  parameter int SCORE_MAX     = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic [3:0]  req,
  output logic [5:0]  cell_addr,
  input  logic [2:0]  cell_group,
  input  logic        cell_next,
  output logic [63:0] state,
  output logic        busy,
  output logic        commit,
  output logic        drop,
  output logic        empty,
  output logic [13:0] score
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    COMMIT,
    SETTLE
  } fsm_t;

  fsm_t fsm_q, fsm_d;

  logic [3:0]    req_q;
  logic [3:0]    rise;
  logic          rise_any;
  logic          rise_multi;
  logic [1:0]    rise_code;
  logic [1:0]    acc_code;
  logic          accept;
  logic          drop_d;
  logic [5:0]    k;
  logic [2:0]    grp;
  logic [63:0]   shadow;
  logic [CW-1:0] cnt;
  logic          q_valid;
  logic [1:0]    q_head;

  assign rise       = req & ~req_q;
  assign rise_any   = |rise;
  assign rise_multi = |(rise & (rise - 4'd1));

  always_comb begin
    rise_code = 2'd0;
    if (rise[3])      rise_code = 2'd3;
    else if (rise[2]) rise_code = 2'd2;
    else if (rise[1]) rise_code = 2'd1;
  end

`ifdef CA_REQ_QUEUE_EN
  localparam int AW = $clog2(QDEPTH);

  logic [1:0]    q_mem [QDEPTH];
  logic [AW-1:0] q_rd;
  logic [AW-1:0] q_wr;
  logic [AW:0]   q_cnt;
  logic          q_full;
  logic          pop;
  logic          push;

  assign q_valid = (q_cnt != '0);
  assign q_full  = (q_cnt == (AW+1)'(QDEPTH));
  assign q_head  = q_mem[q_rd];

  always_ff @(posedge clk) begin
    if (reset || load) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      if (push) begin
        q_mem[q_wr] <= rise_code;
        q_wr        <= q_wr + 1'b1;
      end
      if (pop) q_rd <= q_rd + 1'b1;
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end
`else
  assign q_valid = 1'b0;
  assign q_head  = 2'd0;
`endif

  // Request arbitration: queue head first, losers of a tie are dropped.
  always_comb begin
    accept   = 1'b0;
    acc_code = rise_code;
    drop_d   = rise_multi & ~load;
`ifdef CA_REQ_QUEUE_EN
    pop  = 1'b0;
    push = 1'b0;
`endif
    if (!load && fsm_q == IDLE) begin
      if (q_valid) begin
        acc_code = q_head;
        accept   = ~empty;
        drop_d   = drop_d | empty;
`ifdef CA_REQ_QUEUE_EN
        pop  = 1'b1;
        push = rise_any;
`endif
      end else if (rise_any) begin
        accept = ~empty;
        drop_d = drop_d | empty;
      end
    end else if (!load && rise_any) begin
`ifdef CA_REQ_QUEUE_EN
      push = 1'b1;
`else
      drop_d = 1'b1;
`endif
    end
`ifdef CA_REQ_QUEUE_EN
    if (push && q_full && !pop) begin
      push   = 1'b0;
      drop_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:   if (accept) fsm_d = SWEEP;
      SWEEP:  if (k == 6'd63) fsm_d = COMMIT;
      COMMIT: fsm_d = SETTLE;
      SETTLE: if (cnt == '0) fsm_d = IDLE;
    endcase
    if (load) fsm_d = IDLE;
  end

  always_comb begin
    busy      = (fsm_q != IDLE);
    cell_addr = k;
    empty     = (state == 64'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q  <= '0;
      state  <= '0;
      shadow <= '0;
      score  <= '0;
      k      <= '0;
      grp    <= '0;
      cnt    <= '0;
      commit <= 1'b0;
      drop   <= 1'b0;
    end else begin
      req_q  <= req;
      commit <= 1'b0;
      drop   <= drop_d;
      if (load) begin
        state <= load_data;
        score <= '0;
        k     <= '0;
      end else begin
        unique case (fsm_q)
          IDLE: begin
            if (accept) begin
              grp <= {1'b0, acc_code} + 3'd1;
              k   <= '0;
              if (score < 14'(SCORE_MAX)) score <= score + 14'd1;
            end
          end
          SWEEP: begin
            shadow[k] <= (cell_group == grp) ? cell_next : state[k];
            k         <= k + 6'd1;
          end
          COMMIT: begin
            state  <= shadow;
            commit <= 1'b1;
            cnt    <= CW'(SETTLE_CYCLES - 1);
          end
          SETTLE: begin
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ca_sweep_scheduler.sv
// Directed bench for ca_sweep_scheduler with an XOR-of-neighbours rule
// and quadrant groups (1=top-left, 2=top-right, 3=bottom-left, 4=bottom-right).
module tb_ca_sweep_scheduler;

  localparam int S = 8;
  localparam logic [63:0] P  = 64'h0000_0018_1800_0000;
  localparam logic [63:0] G1 = 64'h0000_0018_1408_0000;
  localparam logic [63:0] G4 = 64'h0000_1028_1800_0000;
  localparam logic [63:0] Q  = 64'h8000_0000_0000_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [63:0] load_data;
  logic [3:0]  req;
  logic [5:0]  cell_addr;
  logic [2:0]  cell_group;
  logic        cell_next;
  logic [63:0] state;
  logic        busy;
  logic        commit;
  logic        drop;
  logic        empty;
  logic [13:0] score;
  logic        nb_n, nb_s, nb_e, nb_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ca_sweep_scheduler #(
    .SETTLE_CYCLES(S),
    .QDEPTH(4),
    .SCORE_MAX(9999)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_data(load_data),
    .req(req),
    .cell_addr(cell_addr),
    .cell_group(cell_group),
    .cell_next(cell_next),
    .state(state),
    .busy(busy),
    .commit(commit),
    .drop(drop),
    .empty(empty),
    .score(score)
  );

  always_comb begin
    cell_group = {1'b0, cell_addr[5], cell_addr[2]} + 3'd1;
    nb_n = (cell_addr[5:3] != 3'd0) ? state[cell_addr - 6'd8] : 1'b0;
    nb_s = (cell_addr[5:3] != 3'd7) ? state[cell_addr + 6'd8] : 1'b0;
    nb_w = (cell_addr[2:0] != 3'd0) ? state[cell_addr - 6'd1] : 1'b0;
    nb_e = (cell_addr[2:0] != 3'd7) ? state[cell_addr + 6'd1] : 1'b0;
    cell_next = nb_n ^ nb_s ^ nb_e ^ nb_w;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] d);
    load      = 1'b1;
    load_data = d;
    req       = 4'd0;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_commit();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (commit) seen = 1'b1;
    end
    check("commit_seen", 64'(seen), 64'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    check("idle_seen", 64'(done), 64'd1);
  endtask

  initial begin
    int nc;
    int nd;
    int cyc;
    int first_c;
    int last_c;
    reset     = 1'b1;
    load      = 1'b0;
    load_data = '0;
    req       = '0;
    tick();
    tick();
    check("rst_state", state, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_commit", 64'(commit), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_score", 64'(score), 64'd0);
    check("rst_addr", 64'(cell_addr), 64'd0);
    reset = 1'b0;
    tick();

    // single group-1 move
    do_load(P);
    check("load_state", state, P);
    check("load_empty", 64'(empty), 64'd0);
    req = 4'b0001;
    tick();
    req = 4'd0;
    check("m1_busy", 64'(busy), 64'd1);
    check("m1_score", 64'(score), 64'd1);
    for (int i = 0; i < 64; i++) begin
      check("m1_addr", 64'(cell_addr), 64'(i));
      check("m1_nocommit", 64'(commit), 64'd0);
      tick();
    end
    check("m1_commit_pre", 64'(commit), 64'd0);
    check("m1_state_pre", state, P);
    tick();
    check("m1_commit", 64'(commit), 64'd1);
    check("m1_state", state, G1);
    tick();
    check("m1_commit_pulse", 64'(commit), 64'd0);
    repeat (S - 2) tick();
    check("m1_busy_last", 64'(busy), 64'd1);
    tick();
    check("m1_busy_fall", 64'(busy), 64'd0);

    // simultaneous rises on groups 2 and 4
    do_load(P);
    req = 4'b1010;
    tick();
    req = 4'd0;
    check("m2_drop", 64'(drop), 64'd1);
    check("m2_busy", 64'(busy), 64'd1);
    check("m2_score", 64'(score), 64'd1);
    tick();
    check("m2_drop_pulse", 64'(drop), 64'd0);
    wait_commit();
    check("m2_state", state, G4);
    wait_idle();

`ifndef CA_REQ_QUEUE_EN
    // rise during sweep is rejected
    do_load(P);
    req = 4'b0001;
    tick();
    req = 4'd0;
    repeat (9) tick();
    req = 4'b0100;
    tick();
    req = 4'd0;
    check("m3_drop", 64'(drop), 64'd1);
    nc = 0;
    for (int i = 0; i < 3 * (S + 66); i++) begin
      tick();
      if (commit) nc++;
    end
    check("m3_commits", 64'(nc), 64'd1);
    check("m3_state", state, G1);
    check("m3_score", 64'(score), 64'd1);
`else
    // six rises during one settle window
    do_load(P);
    req = 4'b0001;
    tick();
    req = 4'd0;
    wait_commit();
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      req = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      tick();
      if (drop) nd++;
    end
    req = 4'd0;
    check("q_drops", 64'(nd), 64'd2);
    nc      = 0;
    cyc     = 6;
    first_c = 0;
    last_c  = 0;
    for (int i = 0; i < 5 * (S + 66); i++) begin
      tick();
      cyc++;
      if (commit) begin
        if (nc == 0) first_c = cyc;
        last_c = cyc;
        nc++;
      end
    end
    check("q_commits", 64'(nc), 64'd4);
    check("q_first_gap", 64'(first_c), 64'(S + 66));
    check("q_span", 64'(last_c - first_c), 64'(3 * (S + 66)));
    check("q_score", 64'(score), 64'd5);
`endif

    // empty board rejects requests
    do_load(64'd0);
    check("e_empty", 64'(empty), 64'd1);
    req = 4'b0001;
    tick();
    req = 4'd0;
    check("e_drop", 64'(drop), 64'd1);
    check("e_score", 64'(score), 64'd0);
    check("e_busy", 64'(busy), 64'd0);
    tick();
    check("e_busy2", 64'(busy), 64'd0);
    check("e_drop_pulse", 64'(drop), 64'd0);

    // load aborts a sweep mid-way
    do_load(P);
    req = 4'b0001;
    tick();
    req = 4'd0;
    repeat (30) tick();
    check("l_addr", 64'(cell_addr), 64'd30);
    load      = 1'b1;
    load_data = Q;
    req       = 4'b1000;
    tick();
    load = 1'b0;
    req  = 4'd0;
    check("l_state", state, Q);
    check("l_busy", 64'(busy), 64'd0);
    check("l_score", 64'(score), 64'd0);
    check("l_drop", 64'(drop), 64'd0);
    nc = 0;
    for (int i = 0; i < 2 * (S + 66); i++) begin
      tick();
      if (commit) nc++;
    end
    check("l_nocommit", 64'(nc), 64'd0);
    check("l_state_hold", state, Q);

    // reset while in COMMIT
    do_load(P);
    req = 4'b0001;
    tick();
    req = 4'd0;
    repeat (64) tick();
    check("r_precommit", 64'(commit), 64'd0);
    reset = 1'b1;
    tick();
    check("r_state", state, 64'd0);
    check("r_busy", 64'(busy), 64'd0);
    check("r_commit", 64'(commit), 64'd0);
    check("r_score", 64'(score), 64'd0);
    check("r_empty", 64'(empty), 64'd1);
    check("r_addr", 64'(cell_addr), 64'd0);
    check("r_drop", 64'(drop), 64'd0);
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ca_sweep_scheduler.md
# ca_sweep_scheduler

Sequencer for the 8x8 cellular-automaton board. It captures group-move requests from the four debounced push-buttons and schedules one move at a time. For each move it sweeps all 64 cells through the shared cell-rule datapath, which computes a cell's next value from its N/E/S/W neighbours and reports the cell's group. It builds the next board in a shadow buffer, then commits it atomically. It also keeps the move score, so the top level only wires the group lookup, the rule logic, the LED-matrix converter and the 7-segment display around it.

## Interface
- SETTLE_CYCLES, 1000, idle cycles after each commit before the next move may start (>=1)
- QDEPTH, 4, request queue depth; used only with CA_REQ_QUEUE_EN (power of 2, >=2)
- SCORE_MAX, 9999, score saturation value; the score fits a 4-digit decimal display
- clk  in  1  clock clk
- reset  in  1  reset reset, synchronous, active-high
- load  in  1  load initial pattern (pulse)
- load_data  in  64  initial board, bit 8*r+c = cell (row r, col c)
- req  in  4  debounced button levels; req[0]=group 1 … req[3]=group 4
- cell_addr  out  6  cell under evaluation, {row[2:0], col[2:0]}
- cell_group  in  3  group (1..4) of cell_addr, combinational from cell_addr
- cell_next  in  1  rule output for cell_addr, combinational from state and cell_addr
- state  out  64  committed board, same bit mapping as load_data
- busy  out  1  move in progress (SWEEP/COMMIT/SETTLE)
- commit  out  1  one-cycle pulse, high in the first cycle the new state is visible
- drop  out  1  one-cycle pulse, a request edge was discarded
- empty  out  1  state == 0
- score  out  14  accepted-move count, saturating at SCORE_MAX

## Operation
- Reset values: state=0, cell_addr=0, busy=0, commit=0, drop=0, empty=1, score=0. The request edge register req_q is 0, the queue is empty and the FSM is in IDLE.
- Request edge detection: rise = req & ~req_q; req_q <= req every cycle.
- Rises in the same cycle: one is selected with priority group 4 > 3 > 2 > 1. Every other rising bit is discarded and drop pulses.
- Requests while empty=1: the request is discarded, drop pulses, score is unchanged and no sweep runs.
- FSM states and transitions:
  - IDLE: when a request is available, latch it into grp and go to SWEEP with k=0. The queue head is preferred over a new rise. On acceptance, score <= min(score+1, SCORE_MAX).
  - SWEEP: cell_addr=k. On each clock, shadow[k] <= (cell_group==grp) ? cell_next : state[k], then k <= k+1. After k=63 is written, go to COMMIT.
  - COMMIT: state <= shadow, commit <= 1, load the settle counter, go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then return to IDLE.
- The rule always reads the committed state, so the update is synchronous: no cell sees a neighbour's new value within a move.
- Rises during busy are handled as defined in Configuration.
- load behaviour:
  - Applies in any state and takes priority over requests in the same cycle.
  - Sets state <= load_data, score <= 0 and flushes the queue.
  - Aborts any sweep or settle without a commit and returns to IDLE.
  - Rises in the same cycle are ignored; drop stays 0.
- reset has priority over load.

## Timing
- A rise sampled at edge t in IDLE puts the FSM in SWEEP after edge t.
  - busy=1 and cell_addr=0 from edge t.
  - cell_addr steps 0..63 over cycles t..t+63.
  - The new state and commit=1 appear after edge t+65.
  - busy falls after edge t+66+SETTLE_CYCLES-1 (SETTLE lasts exactly SETTLE_CYCLES cycles).
- A queued request starts in the first IDLE cycle (zero gap beyond SETTLE).
- score updates on the acceptance edge t. drop pulses on the edge where the discard is decided.
- empty is combinational from the registered state.

## Configuration
- CA_REQ_QUEUE_EN defined:
  - Selected rises that arrive while busy, or while IDLE is starting another move, are pushed into a QDEPTH-entry FIFO of 2-bit group codes.
  - A push when the FIFO is full is discarded with drop=1.
  - Simultaneous pop and push in the same cycle is allowed.
- CA_REQ_QUEUE_EN undefined:
  - No FIFO is built.
  - Any rise while busy is discarded with drop=1.

## Test plan
- Single move:
  - Stimulus: load 64'h0000_0018_1800_0000, rise on req[0] at edge t.
  - Required: cell_addr 0..63 over t..t+63; commit=1 only after edge t+65; state equals the golden rule applied to group-1 cells only; score=1.
- Simultaneous rises on req[1] and req[3]: group 4 swept, drop=1 for one cycle, score=1.
- Busy rejection (macro off): rise on req[2] 10 cycles into SWEEP → drop=1, exactly one commit.
- Queueing (macro on, QDEPTH=4):
  - Stimulus: 6 rises during one SETTLE.
  - Required: 4 queued and 2 dropped; 5 commits total, each SETTLE_CYCLES+66 cycles apart; score=5.
- Empty board: load 0, rise on req[0] → drop=1, score=0, busy stays 0.
- load at cell_addr=30: no commit, state=load_data on the next cycle, score=0, FSM IDLE, queue empty.
- reset during COMMIT → all outputs return to their reset values the next cycle.
